// File: rtl/axis_addr_arb_pkg.sv
// rtl/axis_addr_arb_pkg.sv - shared types and helpers for the write-address arbiter
package axis_addr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    // Ceiling log2, used to size counters from elaboration-time constants.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_ord_fifo.sv
// rtl/axis_ord_fifo.sv - grant-order FIFO with registered head
module axis_ord_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_next;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  do_push;
    logic                  do_pop;
    logic                  bypass;

    // Qualify push/pop and work out which entry becomes the next head.
    always_comb begin
        do_pop      = pop && (count != '0);
        do_push     = push && ((count != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_next = do_pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
        count_next  = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_W'(1);
        end
        // The pushed entry lands straight in the head when nothing older survives.
        bypass = do_push && ((count == '0) || ((count == CNT_W'(1)) && do_pop));
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (bypass) begin
                head_data <= push_data;
            end else if (count_next != '0) begin
                head_data <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/axis_addr_arb.sv
// rtl/axis_addr_arb.sv - round-robin arbiter sharing one AXI write-address channel
module axis_addr_arb
    import axis_addr_arb_pkg::*;
#(
    parameter int NB_PORTS       = 2,
    parameter int ID_WIDTH       = 1,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ORD_DEPTH_LOG2 = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NB_PORTS*AXI_ADDR_WIDTH-1:0] req_aaddr,
    input  logic [NB_PORTS*AXI_LEN_WIDTH-1:0]  req_alen,
    input  logic [NB_PORTS-1:0]                req_avalid,
    output logic [NB_PORTS-1:0]                req_aready,
    output logic [AXI_ADDR_WIDTH-1:0]          axi_aaddr,
    output logic [AXI_LEN_WIDTH-1:0]           axi_alen,
    output logic                               axi_avalid,
    input  logic                               axi_aready,
    output logic [ID_WIDTH-1:0]                ord_id,
    output logic [AXI_LEN_WIDTH-1:0]           ord_len,
    output logic                               ord_valid,
    input  logic                               ord_ready
);
    localparam int DEPTH  = 1 << ORD_DEPTH_LOG2;
    localparam int OCC_W  = clog2(DEPTH + 1);
    localparam int FIFO_W = ID_WIDTH + AXI_LEN_WIDTH;

    arb_state_e              state_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [OCC_W-1:0]        occ_q;

    logic                    hs;
    logic                    pop;
    logic                    room;
    logic                    may_grant;
    logic                    grant;
    logic [ID_WIDTH-1:0]     next_after_id;
    logic [ID_WIDTH-1:0]     base;
    logic                    hit_hi;
    logic                    hit_lo;
    logic [ID_WIDTH-1:0]     idx_hi;
    logic [ID_WIDTH-1:0]     idx_lo;
    logic [ID_WIDTH-1:0]     gnt_id;
    logic [AXI_ADDR_WIDTH-1:0] gnt_addr;
    logic [AXI_LEN_WIDTH-1:0]  gnt_len;
    logic [FIFO_W-1:0]       fifo_head;

    // Decide whether a grant may be issued this cycle and where the search starts.
    always_comb begin
        hs            = (state_q == ST_ISSUE) && axi_aready;
        pop           = ord_valid && ord_ready;
        room          = (occ_q < OCC_W'(DEPTH)) || pop;
        may_grant     = rst_n && room && ((state_q == ST_IDLE) || hs);
        next_after_id = (id_q == ID_WIDTH'(NB_PORTS - 1)) ? '0 : id_q + ID_WIDTH'(1);
        // A regrant on handshake already sees the pointer advanced past the winner.
        base          = hs ? next_after_id : ptr_q;
    end

    // Round-robin search: lowest requester at or above base, else lowest overall.
    always_comb begin
        hit_hi     = 1'b0;
        hit_lo     = 1'b0;
        idx_hi     = '0;
        idx_lo     = '0;
        for (int p = NB_PORTS - 1; p >= 0; p--) begin
            if (req_avalid[p]) begin
                hit_lo = 1'b1;
                idx_lo = ID_WIDTH'(p);
                if (p >= int'(base)) begin
                    hit_hi = 1'b1;
                    idx_hi = ID_WIDTH'(p);
                end
            end
        end
        gnt_id     = hit_hi ? idx_hi : idx_lo;
        grant      = may_grant && hit_lo;
        gnt_addr   = '0;
        gnt_len    = '0;
        req_aready = '0;
        for (int p = 0; p < NB_PORTS; p++) begin
            if (gnt_id == ID_WIDTH'(p)) begin
                gnt_addr      = req_aaddr[p*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                gnt_len       = req_alen[p*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
                req_aready[p] = grant;
            end
        end
    end

    // Issue FSM with registered address outputs, pointer and credit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            axi_avalid <= 1'b0;
            axi_aaddr  <= '0;
            axi_alen   <= '0;
            id_q       <= '0;
            ptr_q      <= '0;
            occ_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        state_q    <= ST_ISSUE;
                        axi_avalid <= 1'b1;
                        axi_aaddr  <= gnt_addr;
                        axi_alen   <= gnt_len;
                        id_q       <= gnt_id;
                    end
                end
                ST_ISSUE: begin
                    if (axi_aready) begin
                        ptr_q <= next_after_id;
                        if (grant) begin
                            axi_aaddr <= gnt_addr;
                            axi_alen  <= gnt_len;
                            id_q      <= gnt_id;
                        end else begin
                            state_q    <= ST_IDLE;
                            axi_avalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    axi_avalid <= 1'b0;
                end
            endcase
            if (grant && !pop) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (!grant && pop) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    axis_ord_fifo #(
        .WIDTH      (FIFO_W),
        .DEPTH_LOG2 (ORD_DEPTH_LOG2)
    ) u_ord_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (hs),
        .push_data  ({id_q, axi_alen}),
        .pop        (ord_ready),
        .head_data  (fifo_head),
        .head_valid (ord_valid)
    );

    assign ord_id  = fifo_head[FIFO_W-1 -: ID_WIDTH];
    assign ord_len = fifo_head[AXI_LEN_WIDTH-1:0];

endmodule
